lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
Load/store controller sitting directly upstream of data_mem in the core's memory stage. Accepts byte/half/word load and store requests from the execute stage and checks alignment and range. Drives data_mem's word-addressed port, performing read-modify-write for sub-word stores. Returns sign- or zero-extended load data through a valid/ready response handshake.

Parameters:
DATA_WIDTH, 32, data path width; only 32 is supported.
MEM_SIZE, 32, number of words in data_mem.
MEM_ADDR_W, 5, data_mem word-address width; must be >= $clog2(MEM_SIZE).

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_is_store  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
req_unsigned  in  1  load zero-extends when 1 (LBU/LHU)
req_addr  in  32  byte address
req_wdata  in  32  store data; sub-word taken from the LSBs
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, out-of-range or illegal-size request
mem_addr  out  MEM_ADDR_W  word index = req_addr[MEM_ADDR_W+1:2]
mem_rd_en  out  1  data_mem read enable
mem_wr_en  out  1  data_mem write enable
mem_wr_data  out  32  full word to write
mem_ld_data  in  32  data_mem combinational read data

Behaviour:
- Clock, reset: one clock (clk). Reset is asynchronous and active-high (reset). Reset forces state IDLE and clears the request registers.
- Reset values: req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_rd_en=0; mem_wr_en=0; mem_wr_data=0; mem_addr=0.
- Capture: on accept (req_valid && req_ready), register all request fields.
- Error conditions, checked on the registered request:
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:2] >= MEM_SIZE
- On any error: no memory access, resp_err=1.
- States:
  - IDLE: req_ready=1 only in IDLE. On accept:
    - error -> RESP
    - load -> LD
    - word store -> WR (write word = req_wdata)
    - byte/half store -> RMW
  - LD: mem_rd_en=1. Select the lane by addr[1:0] (byte lane = addr[1:0]; half lane = addr[1]). Sign- or zero-extend into resp_rdata, then -> RESP.
  - RMW: mem_rd_en=1. Merge the store lane into mem_ld_data and register the result as the write word, then -> WR.
  - WR: mem_wr_en=1 and mem_wr_data=write word for exactly one cycle, then -> RESP.
  - RESP: resp_valid=1, outputs held stable until resp_ready; on handshake -> IDLE. No new request is accepted in the handshake cycle.
- Latency, with accept in cycle N:
  - error: resp_valid at N+1
  - load: N+2
  - word store: N+2
  - sub-word store: N+3
- Outputs outside active states:
  - mem_rd_en=0 and mem_wr_en=0 outside LD, RMW and WR.
  - mem_wr_data=0 outside WR.
  - mem_addr holds its last value.
- Reset mid-operation:
  - Abandons the transaction and drops any pending response.
  - A WR cycle either completes fully at the clock edge or is not issued; no partial write.
- Exactly one outstanding transaction; no pipelining.

Optional Feature:
- Macro LSU_PERF_CNT_EN.
- Defined: adds outputs cnt_load, cnt_store, cnt_err (32 bits each). Each increments on the RESP handshake of a successful load, a successful store, or an errored request respectively. Counters wrap at 2^32 and reset to 0.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Memory word 3 = 0x8081_F0AA; LB addr 0x0D -> resp_rdata 0xFFFF_FFF0 at N+2; LBU addr 0x0D -> 0x0000_00F0.
- Word 3 = 0x8081_F0AA; SB 0x55 to addr 0x0E -> one RMW read, then a single write 0x8055_F0AA to word 3; resp_valid at N+3 with resp_err=0.
- SW 0x1234_5678 to addr 0x10 -> mem_wr_en high for exactly one cycle with word 4 and 0x1234_5678; no mem_rd_en pulse.
- LH addr 0x03, LW addr 0x06, size 11, and LW addr 0x80 (MEM_SIZE=32) -> each gives resp_err=1 at N+1 with no mem_rd_en/mem_wr_en activity.
- resp_ready held low 5 cycles after a load -> resp_valid and resp_rdata stable and req_ready=0 throughout; accept resumes the cycle after the handshake.
- Assert reset during RMW of a SB -> all outputs return to reset values immediately; no write to memory; with LSU_PERF_CNT_EN the counters read 0.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: byte/half/word load-store controller in front of a word-addressed data_mem.
// Define LSU_PERF_CNT_EN to add the cnt_load/cnt_store/cnt_err performance counters.
module lsu_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 32,
  parameter int MEM_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_ld_data
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]           cnt_load,
  output logic [31:0]           cnt_store,
  output logic [31:0]           cnt_err
`endif
);

  // IDLE wait for request | LD read+extend | RMW read+merge | WR single write | RESP hold response
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LD   = 3'd1;
  localparam logic [2:0] S_RMW  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [1:0]            size_q, size_d;
  logic                  unsigned_q, unsigned_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [15:0]           wdata_lo_q, wdata_lo_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] wr_word_q, wr_word_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic                  accept;
  logic                  req_err;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;

  assign accept = req_valid && (state_q == S_IDLE);

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11) req_err = 1'b1;
    if (req_size == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_SIZE)) req_err = 1'b1;
  end

  assign ld_byte = mem_ld_data[{addr_lo_q, 3'b000} +: 8];
  assign ld_half = mem_ld_data[{addr_lo_q[1], 4'b0000} +: 16];

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_lo_d  = addr_lo_q;
    wdata_lo_d = wdata_lo_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    wr_word_d  = wr_word_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_lo_d  = req_addr[1:0];
          wdata_lo_d = req_wdata[15:0];
          err_d      = req_err;
          rdata_d    = '0;
          if (req_err) begin
            state_d = S_RESP;
          end else begin
            mem_addr_d = req_addr[MEM_ADDR_W+1:2];
            if (!req_is_store) begin
              state_d = S_LD;
            end else if (req_size == 2'b10) begin
              wr_word_d = req_wdata;
              state_d   = S_WR;
            end else begin
              state_d = S_RMW;
            end
          end
        end
      end
      S_LD: begin
        case (size_q)
          2'b00:   rdata_d = unsigned_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
          2'b01:   rdata_d = unsigned_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
          default: rdata_d = mem_ld_data;
        endcase
        state_d = S_RESP;
      end
      S_RMW: begin
        wr_word_d = mem_ld_data;
        if (size_q == 2'b00) wr_word_d[{addr_lo_q, 3'b000} +: 8] = wdata_lo_q[7:0];
        else                 wr_word_d[{addr_lo_q[1], 4'b0000} +: 16] = wdata_lo_q;
        state_d = S_WR;
      end
      S_WR: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_lo_q  <= 2'b00;
      wdata_lo_q <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      wr_word_q  <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_lo_q  <= addr_lo_d;
      wdata_lo_q <= wdata_lo_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      wr_word_q  <= wr_word_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // All strobes decode straight from the state flop, so reset kills a WR before any edge sees it.
  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_rdata  = resp_valid ? rdata_q : '0;
  assign resp_err    = resp_valid && err_q;
  assign mem_addr    = mem_addr_q;
  assign mem_rd_en   = (state_q == S_LD) || (state_q == S_RMW);
  assign mem_wr_en   = (state_q == S_WR);
  assign mem_wr_data = mem_wr_en ? wr_word_q : '0;

`ifdef LSU_PERF_CNT_EN
  logic        is_store_q, is_store_d;
  logic [31:0] cnt_load_q, cnt_load_d;
  logic [31:0] cnt_store_q, cnt_store_d;
  logic [31:0] cnt_err_q, cnt_err_d;

  always_comb begin
    is_store_d  = is_store_q;
    cnt_load_d  = cnt_load_q;
    cnt_store_d = cnt_store_q;
    cnt_err_d   = cnt_err_q;
    if (accept) is_store_d = req_is_store;
    if (resp_valid && resp_ready) begin
      if (err_q)           cnt_err_d   = cnt_err_q + 32'd1;
      else if (is_store_q) cnt_store_d = cnt_store_q + 32'd1;
      else                 cnt_load_d  = cnt_load_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_store_q  <= 1'b0;
      cnt_load_q  <= '0;
      cnt_store_q <= '0;
      cnt_err_q   <= '0;
    end else begin
      is_store_q  <= is_store_d;
      cnt_load_q  <= cnt_load_d;
      cnt_store_q <= cnt_store_d;
      cnt_err_q   <= cnt_err_d;
    end
  end

  assign cnt_load  = cnt_load_q;
  assign cnt_store = cnt_store_q;
  assign cnt_err   = cnt_err_q;
`endif

endmodule
